ex_muldiv_unit: RTL and testbench

Iterative multiply/divide unit in the EX stage, fed by the ID/EX pipeline register's rs/rt data and decoded mul/div op.
Computes MULT/MULTU/DIV/DIVU into architectural HI/LO registers over multiple cycles.
Drives a stall request back to the hazard unit so that a dependent MFHI/MFLO or a second mul/div waits in ID until the result lands.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/ex_div_core.sv | 44 ++++
 rtl/ex_muldiv_unit.sv | 172 +++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: op codes, FSM states, default width.
package muldiv_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_mul(input logic [1:0] op);
    return ~op[1];
  endfunction

endpackage

// File: rtl/ex_div_core.sv
// Restoring divider datapath on unsigned magnitudes: one quotient bit per enabled step.
// The *_next outputs show the result of the step taken on the coming edge.
module ex_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quo_next,
  output logic [WIDTH-1:0] o_rem_next
);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;

  // A zero divisor never restores, so the remainder ends up holding the dividend.
  always_comb begin
    w_shift    = {r_rem, r_quo[WIDTH-1]};
    w_diff     = w_shift - {1'b0, i_divisor};
    w_qbit     = ~w_diff[WIDTH];
    o_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    o_quo_next = {r_quo[WIDTH-2:0], w_qbit};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rem <= '0;
      r_quo <= '0;
    end else if (i_load) begin
      r_rem <= '0;
      r_quo <= i_dividend;
    end else if (i_step) begin
      r_rem <= o_rem_next;
      r_quo <= o_quo_next;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing HI/LO, with a stall request to the hazard unit.
// Define MULDIV_FAST_MULT_EN to compute multiplies in a single RUN cycle.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rsdata_i,
  input  logic [WIDTH-1:0] rtdata_i,
  input  logic             hilo_rd_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic             divzero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output state_t           dbg_state_o
);

  // Handshake: an op is taken on an edge where state is IDLE, start_i is high and
  // flush_i is low; whenever busy, stall_o holds start_i/hilo_rd_i upstream in ID.
  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_cnt;
  logic              r_is_mul;
  logic              r_neg_lo;
  logic              r_neg_hi;
  logic              r_divzero;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_hi;
  logic [WIDTH-1:0]  r_lo;

  logic              w_accept;
  logic              w_last;
  logic              w_commit;
  logic              w_busy;
  logic              w_done;
  logic              w_sgn;
  logic              w_rs_neg;
  logic              w_rt_neg;
  logic [WIDTH-1:0]  w_rs_mag;
  logic [WIDTH-1:0]  w_rt_mag;
  logic [WIDTH-1:0]  w_quo_next;
  logic [WIDTH-1:0]  w_rem_next;
  logic [2*WIDTH-1:0] w_mul_mag;
  logic [2*WIDTH-1:0] w_prod;

  assign w_sgn    = op_is_signed(op_i);
  assign w_rs_neg = w_sgn & rsdata_i[WIDTH-1];
  assign w_rt_neg = w_sgn & rtdata_i[WIDTH-1];
  assign w_rs_mag = w_rs_neg ? -rsdata_i : rsdata_i;
  assign w_rt_mag = w_rt_neg ? -rtdata_i : rtdata_i;
  assign w_accept = (r_state == IDLE) & start_i & ~flush_i;

`ifdef MULDIV_FAST_MULT_EN
  assign w_mul_mag = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
  assign w_last    = r_is_mul | (r_cnt == CNT_LAST);
`else
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH:0]     w_sum;

  // Shift-add: the multiplier sits in the low half and is consumed LSB first.
  assign w_sum     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : '0);
  assign w_mul_mag = {w_sum, r_prod[WIDTH-1:1]};
  assign w_last    = (r_cnt == CNT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_prod <= '0;
    end else if (w_accept) begin
      r_prod <= {{WIDTH{1'b0}}, w_rt_mag};
    end else if (r_state == RUN) begin
      r_prod <= w_mul_mag;
    end
  end
`endif

  ex_div_core #(.WIDTH(WIDTH)) u_div (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_load     (w_accept),
    .i_step     ((r_state == RUN) & ~r_is_mul),
    .i_dividend (w_rs_mag),
    .i_divisor  (r_b),
    .o_quo_next (w_quo_next),
    .o_rem_next (w_rem_next)
  );

  assign w_prod   = r_neg_lo ? -w_mul_mag : w_mul_mag;
  assign w_commit = (r_state == RUN) & ~flush_i & w_last;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN: begin
        if (flush_i)     w_next = IDLE;
        else if (w_last) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == RUN) | (r_state == DONE);
    w_done = (r_state == DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_is_mul  <= 1'b0;
      r_neg_lo  <= 1'b0;
      r_neg_hi  <= 1'b0;
      r_divzero <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_a       <= w_rs_mag;
      r_b       <= w_rt_mag;
      r_is_mul  <= op_is_mul(op_i);
      r_neg_lo  <= w_rs_neg ^ w_rt_neg;
      r_neg_hi  <= w_rs_neg;
      r_divzero <= op_i[1] & (rtdata_i == '0);
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Divide-by-zero needs no special HI path: the sign-fixed remainder equals rsdata.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      if (r_is_mul) begin
        {r_hi, r_lo} <= w_prod;
      end else begin
        r_hi <= r_neg_hi ? -w_rem_next : w_rem_next;
        r_lo <= r_divzero ? '1 : (r_neg_lo ? -w_quo_next : w_quo_next);
      end
    end
  end

  assign busy_o      = w_busy;
  assign done_o      = w_done;
  assign divzero_o   = w_done & r_divzero;
  assign stall_o     = w_busy & (start_i | hilo_rd_i);
  assign hi_o        = r_hi;
  assign lo_o        = r_lo;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed cases, randomized ops against an arithmetic model,
// flush/reset aborts and stall/back-to-back behaviour.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk_i     = 1'b0;
  logic         rst_i     = 1'b1;
  logic         start_i   = 1'b0;
  logic [1:0]   op_i      = 2'b00;
  logic [W-1:0] rsdata_i  = '0;
  logic [W-1:0] rtdata_i  = '0;
  logic         hilo_rd_i = 1'b0;
  logic         flush_i   = 1'b0;
  logic         busy_o;
  logic         stall_o;
  logic         done_o;
  logic         divzero_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;
  state_t       dbg_state_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [W-1:0] edge_vals [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE};

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .op_i        (op_i),
    .rsdata_i    (rsdata_i),
    .rtdata_i    (rtdata_i),
    .hilo_rd_i   (hilo_rd_i),
    .flush_i     (flush_i),
    .busy_o      (busy_o),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .divzero_o   (divzero_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .dbg_state_o (dbg_state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic, truncating signed division.
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] eh, output logic [W-1:0] el, output logic edz);
    longint       sa, sb, q, r;
    logic [63:0]  p;
    edz = 1'b0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (op)
      OP_MULT:  begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
      OP_MULTU: begin p = {32'h0, a} * {32'h0, b}; eh = p[63:32]; el = p[31:0]; end
      default: begin
        if (b == '0) begin
          eh = a; el = '1; edz = 1'b1;
        end else if (op == OP_DIVU) begin
          el = a / b; eh = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          el = q[31:0]; eh = r[31:0];
        end
      end
    endcase
  endtask

  function automatic int exp_lat(input logic [1:0] op);
`ifdef MULDIV_FAST_MULT_EN
    if (op[1] == 1'b0) return 2;
`endif
    return (op == op) ? W + 1 : W + 1;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eh, el;
    logic         edz;
    int           lat, bc;
    bit           dz_early;
    model(op, a, b, eh, el, edz);
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; rsdata_i = a; rtdata_i = b;
    lat = 0; bc = 0; dz_early = 1'b0;
    while (!done_o && lat < 80) begin
      @(negedge clk_i);
      start_i = 1'b0;
      lat++;
      if (busy_o) bc++;
      if (!done_o && divzero_o) dz_early = 1'b1;
    end
    check("done_latency", 64'(lat), 64'(exp_lat(op)));
    check("busy_cycles", 64'(bc), 64'(exp_lat(op)));
    check("done_state", 64'(dbg_state_o), 64'(DONE));
    check("hi", 64'(hi_o), 64'(eh));
    check("lo", 64'(lo_o), 64'(el));
    check("divzero_at_done", 64'(divzero_o), 64'(edz));
    check("divzero_early", 64'(dz_early), 64'(0));
    @(negedge clk_i);
    check("done_pulse_end", 64'(done_o), 64'(0));
    check("divzero_pulse_end", 64'(divzero_o), 64'(0));
    check("busy_after_done", 64'(busy_o), 64'(0));
  endtask

  initial begin
    logic [W-1:0] eh1, el1, eh2, el2, ra, rb;
    logic         edz;
    logic [1:0]   rop;
    int           lat, dn;

    // reset state, with requests present to show no stall while idle
    start_i = 1'b1; hilo_rd_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("rst_hi", 64'(hi_o), 64'(0));
    check("rst_lo", 64'(lo_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_stall", 64'(stall_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    check("rst_divzero", 64'(divzero_o), 64'(0));
    check("rst_state", 64'(dbg_state_o), 64'(IDLE));
    start_i = 1'b0; hilo_rd_i = 1'b0;
    rst_i = 1'b0;
    @(negedge clk_i);

    // directed cases
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_max_hi", 64'(hi_o), 64'h0FFFFFFFE);
    check("multu_max_lo", 64'(lo_o), 64'h1);
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd5);
    check("mult_neg_hi", 64'(hi_o), 64'h0FFFFFFFF);
    check("mult_neg_lo", 64'(lo_o), 64'h0FFFFFFF1);
    run_op(OP_DIVU, 32'd7, 32'd2);
    check("divu_lo", 64'(lo_o), 64'd3);
    check("divu_hi", 64'(hi_o), 64'd1);
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
    check("div_neg_lo", 64'(lo_o), 64'h0FFFFFFFD);
    check("div_neg_hi", 64'(hi_o), 64'h0FFFFFFFF);
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf_lo", 64'(lo_o), 64'h080000000);
    check("div_ovf_hi", 64'(hi_o), 64'h0);
    run_op(OP_DIV, 32'h1234, 32'h0);
    check("divz_hi", 64'(hi_o), 64'h1234);
    check("divz_lo", 64'(lo_o), 64'h0FFFFFFFF);
    run_op(OP_DIV, 32'd7, 32'hFFFFFFFE);
    run_op(OP_DIV, 32'hFFFFFFF9, 32'hFFFFFFFE);
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h0);
    run_op(OP_MULT, 32'h80000000, 32'h80000000);

    // randomized ops
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = 32'($urandom_range(0, 40)) - 32'd20; rb = 32'($urandom_range(0, 12)) - 32'd6; end
        2: begin ra = $urandom; rb = '0; end
        3: begin ra = edge_vals[$urandom_range(0, 5)]; rb = edge_vals[$urandom_range(0, 5)]; end
        default: begin ra = $urandom; rb = 32'($urandom_range(1, 300)); end
      endcase
      run_op(rop, ra, rb);
    end

    // preload HI/LO = 0xAAAA/0x5555, then flush in RUN cycle 10
    run_op(OP_DIVU, 32'h5555AAAA, 32'h00010000);
    check("preload_hi", 64'(hi_o), 64'hAAAA);
    check("preload_lo", 64'(lo_o), 64'h5555);
    @(negedge clk_i);
    start_i = 1'b1; op_i = OP_DIV; rsdata_i = 32'd100; rtdata_i = 32'd7;
    repeat (10) begin @(negedge clk_i); start_i = 1'b0; end
    check("flush_pre_state", 64'(dbg_state_o), 64'(RUN));
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flush_state", 64'(dbg_state_o), 64'(IDLE));
    check("flush_busy", 64'(busy_o), 64'(0));
    check("flush_hi", 64'(hi_o), 64'hAAAA);
    check("flush_lo", 64'(lo_o), 64'h5555);
    dn = 0;
    repeat (40) begin @(negedge clk_i); if (done_o) dn++; end
    check("flush_no_done", 64'(dn), 64'(0));
    check("flush_hi_later", 64'(hi_o), 64'hAAAA);

    // flush with start in IDLE suppresses the start
    start_i = 1'b1; flush_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; flush_i = 1'b0;
    check("flush_idle_busy", 64'(busy_o), 64'(0));
    check("flush_idle_state", 64'(dbg_state_o), 64'(IDLE));

    // reset mid-RUN clears everything at once
    @(negedge clk_i);
    start_i = 1'b1; op_i = OP_DIV; rsdata_i = 32'd100; rtdata_i = 32'd7;
    repeat (10) begin @(negedge clk_i); start_i = 1'b0; end
    check("rstmid_pre_busy", 64'(busy_o), 64'(1));
    rst_i = 1'b1; hilo_rd_i = 1'b1;
    #1;
    check("rstmid_hi", 64'(hi_o), 64'(0));
    check("rstmid_lo", 64'(lo_o), 64'(0));
    check("rstmid_busy", 64'(busy_o), 64'(0));
    check("rstmid_stall", 64'(stall_o), 64'(0));
    check("rstmid_done", 64'(done_o), 64'(0));
    check("rstmid_state", 64'(dbg_state_o), 64'(IDLE));
    hilo_rd_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    dn = 0;
    repeat (40) begin @(negedge clk_i); if (done_o) dn++; end
    check("rstmid_no_done", 64'(dn), 64'(0));

    // stall during RUN/DONE, held second start accepted after DONE
    model(OP_DIVU, 32'd1000, 32'd3, eh1, el1, edz);
    model(OP_DIV, 32'hFFFFFFF9, 32'd2, eh2, el2, edz);
    @(negedge clk_i);
    start_i = 1'b1; op_i = OP_DIVU; rsdata_i = 32'd1000; rtdata_i = 32'd3;
    @(negedge clk_i);
    start_i = 1'b0; lat = 1;
    while (lat < 5) begin @(negedge clk_i); lat++; end
    hilo_rd_i = 1'b1;
    #1 check("stall_hilo_rd", 64'(stall_o), 64'(1));
    @(negedge clk_i);
    lat++;
    hilo_rd_i = 1'b0;
    #1 check("stall_quiet_run", 64'(stall_o), 64'(0));
    start_i = 1'b1; op_i = OP_DIV; rsdata_i = 32'hFFFFFFF9; rtdata_i = 32'd2;
    #1 check("stall_start_run", 64'(stall_o), 64'(1));
    while (!done_o && lat < 80) begin @(negedge clk_i); lat++; end
    check("b2b_first_lat", 64'(lat), 64'(exp_lat(OP_DIVU)));
    check("b2b_done_stall", 64'(stall_o), 64'(1));
    check("b2b_first_hi", 64'(hi_o), 64'(eh1));
    check("b2b_first_lo", 64'(lo_o), 64'(el1));
    @(negedge clk_i);
    check("b2b_idle_state", 64'(dbg_state_o), 64'(IDLE));
    check("b2b_idle_stall", 64'(stall_o), 64'(0));
    @(negedge clk_i);
    check("b2b_second_taken", 64'(dbg_state_o), 64'(RUN));
    start_i = 1'b0; lat = 1;
    while (!done_o && lat < 80) begin @(negedge clk_i); lat++; end
    check("b2b_second_lat", 64'(lat), 64'(exp_lat(OP_DIV)));
    check("b2b_second_hi", 64'(hi_o), 64'(eh2));
    check("b2b_second_lo", 64'(lo_o), 64'(el2));
    @(negedge clk_i);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
